// File: rtl/mem_access_stage.sv
// Memory-access stage: issues data-memory requests for loads/stores, aligns and
// extends load data, forwards ALU results, and faults on misalignment/illegal width/timeout.
module mem_access_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  in_ready,
  input  logic [1:0]            mem_op,
  input  logic [2:0]            func3,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [4:0]            rd,
  input  logic                  reg_write_in,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  fault,
  output logic [1:0]            fault_cause
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [0:0]    state;
  logic [CW-1:0] waitCnt;
  logic [2:0]    accFunc3;
  logic [1:0]    accLane;
  logic [4:0]    accRd;

  logic                  isLoad, isStore, illegal, misaligned;
  logic [3:0]            storeBe;
  logic [DATA_WIDTH-1:0] storeWdata;
  logic [DATA_WIDTH-1:0] loadVal;
  logic [7:0]            byteSel;
  logic [15:0]           halfSel;

  assign in_ready = (state == IDLE);

  always_comb begin
    isLoad     = (mem_op == 2'd1);
    isStore    = (mem_op == 2'd2);
    illegal    = 1'b0;
    misaligned = 1'b0;
    storeBe    = 4'b1111;
    storeWdata = store_data;
    if (isLoad) begin
      illegal = !(func3 == 3'd0 || func3 == 3'd1 || func3 == 3'd2 ||
                  func3 == 3'd4 || func3 == 3'd5);
    end else if (isStore) begin
      illegal = !(func3 == 3'd0 || func3 == 3'd1 || func3 == 3'd2);
    end
    // func3[1:0] encodes the access width for both loads and stores
    if (func3[1:0] == 2'd1)      misaligned = alu_result[0];
    else if (func3[1:0] == 2'd2) misaligned = (alu_result[1:0] != 2'b00);
    if (isStore) begin
      case (func3[1:0])
        2'd0: begin
          storeBe    = 4'b0001 << alu_result[1:0];
          storeWdata = {4{store_data[7:0]}};
        end
        2'd1: begin
          storeBe    = alu_result[1] ? 4'b1100 : 4'b0011;
          storeWdata = {2{store_data[15:0]}};
        end
        default: begin
          storeBe    = 4'b1111;
          storeWdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    case (accLane)
      2'd0:    byteSel = dmem_rdata[7:0];
      2'd1:    byteSel = dmem_rdata[15:8];
      2'd2:    byteSel = dmem_rdata[23:16];
      default: byteSel = dmem_rdata[31:24];
    endcase
    halfSel = accLane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (accFunc3)
      3'd0:    loadVal = {{24{byteSel[7]}}, byteSel};
      3'd1:    loadVal = {{16{halfSel[15]}}, halfSel};
      3'd4:    loadVal = {24'd0, byteSel};
      3'd5:    loadVal = {16'd0, halfSel};
      default: loadVal = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      waitCnt     <= '0;
      accFunc3    <= '0;
      accLane     <= '0;
      accRd       <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      fault       <= 1'b0;
      fault_cause <= '0;
    end else begin
      wb_valid <= 1'b0;
      fault    <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (isLoad || isStore) begin
              if (illegal) begin
                fault       <= 1'b1;
                fault_cause <= 2'd2;
              end else if (misaligned) begin
                fault       <= 1'b1;
                fault_cause <= 2'd1;
              end else begin
                dmem_req   <= 1'b1;
                dmem_we    <= isStore;
                dmem_addr  <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
                dmem_be    <= storeBe;
                dmem_wdata <= storeWdata;
                accFunc3   <= func3;
                accLane    <= alu_result[1:0];
                accRd      <= rd;
                waitCnt    <= '0;
                state      <= ACCESS;
              end
            end else begin
              wb_valid <= reg_write_in;
              wb_data  <= alu_result;
              wb_rd    <= rd;
            end
          end
        end
        default: begin
          // ready in the last permitted cycle takes priority over the timeout
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            state    <= IDLE;
            if (!dmem_we) begin
              wb_valid <= (accRd != 5'd0);
              wb_data  <= loadVal;
              wb_rd    <= accRd;
            end
          end else if (waitCnt == CNT_LAST) begin
            dmem_req    <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= 2'd3;
            state       <= IDLE;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected writebacks/faults queued at issue,
// matched when the stage pulses wb_valid or fault.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        in_ready;
  logic [1:0]  mem_op;
  logic [2:0]  func3;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        reg_write_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;
  logic [1:0]  fault_cause;

  mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .in_ready(in_ready),
    .mem_op(mem_op), .func3(func3), .alu_result(alu_result),
    .store_data(store_data), .rd(rd), .reg_write_in(reg_write_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .fault(fault), .fault_cause(fault_cause)
  );

  typedef struct {
    bit          isFault;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expWb(input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.isFault = 1'b0; e.rd = r; e.data = d; e.cause = 2'd0;
    sb.push_back(e);
  endtask

  task automatic expFault(input logic [1:0] c);
    exp_t e;
    e.isFault = 1'b1; e.rd = 5'd0; e.data = 32'd0; e.cause = c;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && (wb_valid || fault)) begin
      if (sb.size() == 0) begin
        checkVal("unexpected_out", {30'd0, wb_valid, fault}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.isFault) begin
          checkVal("fault_pulse", {31'd0, fault}, 32'd1);
          checkVal("fault_cause", {30'd0, fault_cause}, {30'd0, e.cause});
          checkVal("fault_excl_wb", {31'd0, wb_valid}, 32'd0);
        end else begin
          checkVal("wb_valid", {31'd0, wb_valid}, 32'd1);
          checkVal("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          checkVal("wb_data", wb_data, e.data);
          checkVal("wb_excl_fault", {31'd0, fault}, 32'd0);
        end
      end
    end
  end

  // Waits (bounded) for in_ready, presents one instruction for its accept cycle.
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] r, input logic rw);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkVal("issue_wait", {31'd0, in_ready}, 32'd1);
    valid_in = 1'b1; mem_op = op; func3 = f3; alu_result = addr;
    store_data = sdata; rd = r; reg_write_in = rw;
    @(posedge clk); #1;
    valid_in = 1'b0; mem_op = 2'd0; alu_result = 32'hA5A5_0000; rd = 5'd31;
  endtask

  // Called in the first ACCESS cycle: checks the request, waits, then completes it.
  task automatic serve(input int waits, input logic [31:0] rdata, input logic we,
                       input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    checkVal("req_high", {31'd0, dmem_req}, 32'd1);
    checkVal("req_we", {31'd0, dmem_we}, {31'd0, we});
    checkVal("req_addr", dmem_addr, addr);
    checkVal("req_be", {28'd0, dmem_be}, {28'd0, be});
    if (we) checkVal("req_wdata", dmem_wdata, wdata);
    for (int i = 0; i < waits; i++) begin
      checkVal("in_ready_busy", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      checkVal("req_stable_addr", dmem_addr, addr);
    end
    checkVal("in_ready_busy", {31'd0, in_ready}, 32'd0);
    dmem_ready = 1'b1; dmem_rdata = rdata;
    @(posedge clk); #1;
    dmem_ready = 1'b0; dmem_rdata = 32'hDEAD_0000;
    checkVal("req_dropped", {31'd0, dmem_req}, 32'd0);
    checkVal("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic drain(input string tag);
    repeat (2) begin @(posedge clk); #1; end
    checkVal(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1; valid_in = 1'b0; mem_op = 2'd0; func3 = 3'd0; alu_result = '0;
    store_data = '0; rd = '0; reg_write_in = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_req", {31'd0, dmem_req}, 32'd0);
    checkVal("rst_wb", {31'd0, wb_valid}, 32'd0);
    checkVal("rst_fault", {31'd0, fault}, 32'd0);
    checkVal("rst_cause", {30'd0, fault_cause}, 32'd0);
    checkVal("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Stray ready outside ACCESS must have no effect
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    checkVal("stray_ready_req", {31'd0, dmem_req}, 32'd0);

    // Pass-through and reserved op
    expWb(5'd5, 32'h1234);
    issue(2'd0, 3'd0, 32'h1234, 32'd0, 5'd5, 1'b1);
    checkVal("pass_no_req", {31'd0, dmem_req}, 32'd0);
    issue(2'd3, 3'd2, 32'hCAFE_F00D, 32'd0, 5'd9, 1'b0);
    expWb(5'd10, 32'h0BAD_0001);
    issue(2'd3, 3'd7, 32'h0BAD_0001, 32'd0, 5'd10, 1'b1);
    drain("sb_pass");

    // Loads: byte/half/word, signed and unsigned
    expWb(5'd7, 32'hFFFF_FF80);
    issue(2'd1, 3'd0, 32'h103, 32'd0, 5'd7, 1'b0);
    serve(2, 32'h80FF_FF7F, 1'b0, 32'h100, 4'b1111, 32'd0);
    expWb(5'd8, 32'h0000_0080);
    issue(2'd1, 3'd4, 32'h103, 32'd0, 5'd8, 1'b1);
    serve(2, 32'h80FF_FF7F, 1'b0, 32'h100, 4'b1111, 32'd0);
    expWb(5'd11, 32'hFFFF_80FF);
    issue(2'd1, 3'd1, 32'h102, 32'd0, 5'd11, 1'b1);
    serve(0, 32'h80FF_FF7F, 1'b0, 32'h100, 4'b1111, 32'd0);
    expWb(5'd12, 32'h0000_FF7F);
    issue(2'd1, 3'd5, 32'h100, 32'd0, 5'd12, 1'b1);
    serve(1, 32'h80FF_FF7F, 1'b0, 32'h100, 4'b1111, 32'd0);
    expWb(5'd13, 32'h1234_5678);
    issue(2'd1, 3'd2, 32'h104, 32'd0, 5'd13, 1'b1);
    serve(3, 32'h1234_5678, 1'b0, 32'h104, 4'b1111, 32'd0);
    issue(2'd1, 3'd2, 32'h108, 32'd0, 5'd0, 1'b1);
    serve(0, 32'h5555_AAAA, 1'b0, 32'h108, 4'b1111, 32'd0);
    drain("sb_loads");

    // Stores: no writeback expected
    issue(2'd2, 3'd1, 32'h202, 32'hDEAD_BEEF, 5'd3, 1'b0);
    serve(1, 32'd0, 1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF);
    issue(2'd2, 3'd0, 32'h201, 32'h1234_56A5, 5'd3, 1'b0);
    serve(0, 32'd0, 1'b1, 32'h200, 4'b0010, 32'hA5A5_A5A5);
    issue(2'd2, 3'd2, 32'h300, 32'h0102_0304, 5'd3, 1'b1);
    serve(2, 32'd0, 1'b1, 32'h300, 4'b1111, 32'h0102_0304);
    drain("sb_stores");

    // Misaligned and illegal width
    expFault(2'd1);
    issue(2'd1, 3'd2, 32'h101, 32'd0, 5'd4, 1'b1);
    checkVal("misal_no_req", {31'd0, dmem_req}, 32'd0);
    checkVal("misal_in_ready", {31'd0, in_ready}, 32'd1);
    expFault(2'd2);
    issue(2'd2, 3'd3, 32'h200, 32'd0, 5'd4, 1'b0);
    checkVal("illegal_no_req", {31'd0, dmem_req}, 32'd0);
    expFault(2'd1);
    issue(2'd1, 3'd5, 32'h103, 32'd0, 5'd4, 1'b1);
    expFault(2'd2);
    issue(2'd1, 3'd6, 32'h100, 32'd0, 5'd4, 1'b1);
    drain("sb_faults");

    // Timeout: request held for exactly TIMEOUT cycles
    expFault(2'd3);
    issue(2'd1, 3'd2, 32'h400, 32'd0, 5'd6, 1'b1);
    c = 0;
    while (dmem_req && c < 40) begin
      c++;
      @(posedge clk); #1;
    end
    checkVal("timeout_req_cycles", c, 32'd16);
    checkVal("timeout_in_ready", {31'd0, in_ready}, 32'd1);
    drain("sb_timeout");
    expWb(5'd14, 32'h0000_0042);
    issue(2'd0, 3'd0, 32'h42, 32'd0, 5'd14, 1'b1);
    checkVal("cause_held", {30'd0, fault_cause}, 32'd3);
    // Ready arriving in the final permitted cycle wins
    expWb(5'd6, 32'hFACE_0001);
    issue(2'd1, 3'd2, 32'h400, 32'd0, 5'd6, 1'b1);
    serve(15, 32'hFACE_0001, 1'b0, 32'h400, 4'b1111, 32'd0);
    drain("sb_timeout_edge");

    // Reset during the second ACCESS cycle
    issue(2'd1, 3'd2, 32'h500, 32'd0, 5'd15, 1'b1);
    @(posedge clk); #1;
    checkVal("mid_req_before_rst", {31'd0, dmem_req}, 32'd1);
    reset = 1'b1;
    #1;
    checkVal("async_rst_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checkVal("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    expWb(5'd16, 32'h7777_8888);
    issue(2'd1, 3'd2, 32'h504, 32'd0, 5'd16, 1'b1);
    serve(1, 32'h7777_8888, 1'b0, 32'h504, 4'b1111, 32'd0);
    drain("sb_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
